dds_wave_addr_gen: RTL and testbench

- Parametrised phase-accumulator address generator for the waveform ROM of the music player's tone synthesiser.
- Advances a PHASE_W-bit phase by a programmable tuning word on each sample tick.
- Folds the phase into a quarter-wave table address with mirror and sign, or passes a linear ramp address in sawtooth mode.
- Delays sign and valid to line up with ROM read data; sits between the note decoder (tuning word) and the sample ROM / DAC path.

---
 rtl/synth_pkg.sv | 16 +
 rtl/dds_wave_addr_gen_if.sv | 30 +++
 rtl/dds_wave_addr_gen_quarter_fold.sv | 17 +
 rtl/dds_wave_addr_gen.sv | 108 ++++++++++
 tb/tb_dds_wave_addr_gen.sv | 159 +++++++++++++++
 5 files changed

// File: rtl/synth_pkg.sv
// Shared constants for the tone synthesiser path: quadrant codes, wave
// selects and the default phase/address widths.
package synth_pkg;

  localparam logic [1:0] Q0 = 2'd0;
  localparam logic [1:0] Q1 = 2'd1;
  localparam logic [1:0] Q2 = 2'd2;
  localparam logic [1:0] Q3 = 2'd3;

  localparam logic WAVE_SINE = 1'b0;
  localparam logic WAVE_SAW  = 1'b1;

  localparam int DEF_PHASE_W = 24;
  localparam int DEF_ADDR_W  = 10;

endpackage

// File: rtl/dds_wave_addr_gen_if.sv
// Control/address bundle between the note decoder and the wave address generator.
// master = controller side, slave = generator side.
interface dds_wave_addr_gen_if
  import synth_pkg::*;
#(
  parameter int PHASE_W = DEF_PHASE_W,
  parameter int ADDR_W  = DEF_ADDR_W
);
  logic               en;
  logic               sample_tick;
  logic               tune_load;
  logic [PHASE_W-1:0] tune_word;
  logic               phase_clr;
  logic               wave_sel;
  logic [ADDR_W-1:0]  rom_addr;
  logic               addr_valid;
  logic               neg;
  logic               data_valid;
  logic [1:0]         quadrant;

  modport master (
    output en, sample_tick, tune_load, tune_word, phase_clr, wave_sel,
    input  rom_addr, addr_valid, neg, data_valid, quadrant
  );

  modport slave (
    input  en, sample_tick, tune_load, tune_word, phase_clr, wave_sel,
    output rom_addr, addr_valid, neg, data_valid, quadrant
  );
endinterface

// File: rtl/dds_wave_addr_gen_quarter_fold.sv
// Combinational quarter-wave fold: odd quadrants mirror the index, the
// upper half of the cycle carries a negative sign.
module quarter_fold
  import synth_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic [1:0]        q,
  input  logic [ADDR_W-1:0] idx,
  output logic [ADDR_W-1:0] addr,
  output logic              sign
);
  always_comb begin
    addr = ((q == Q1) || (q == Q3)) ? ~idx : idx;
    sign = (q == Q2) || (q == Q3);
  end
endmodule

// File: rtl/dds_wave_addr_gen.sv
// Phase accumulator -> waveform ROM address; addr_valid 1 cycle after a tick,
// neg/data_valid a further ROM_LAT cycles later. Never stalls.
module dds_wave_addr_gen
  import synth_pkg::*;
#(
  parameter int PHASE_W = DEF_PHASE_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int ROM_LAT = 1
) (
  input logic               clk,
  input logic               rst,
  dds_wave_addr_gen_if.slave bus
);
  if ((ROM_LAT < 1) || (ROM_LAT > 4)) begin : g_bad_rom_lat
    $error("dds_wave_addr_gen: ROM_LAT must be in 1..4");
  end
  if (PHASE_W < ADDR_W + 2) begin : g_bad_widths
    $error("dds_wave_addr_gen: PHASE_W must be at least ADDR_W + 2");
  end

  logic [PHASE_W-1:0] tune_q, tune_d;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic               adv_q, adv_d;
  logic [ADDR_W-1:0]  rom_addr_q, rom_addr_d;
  logic [1:0]         quad_q, quad_d;
  logic               sign_q, sign_d;
  logic               addr_valid_q, addr_valid_d;
  logic [ROM_LAT-1:0] dly_vld_q, dly_vld_d;
  logic [ROM_LAT-1:0] dly_sign_q, dly_sign_d;

  logic [1:0]         cur_q;
  logic [ADDR_W-1:0]  fold_addr;
  logic               fold_sign;

  assign cur_q = phase_q[PHASE_W-1 -: 2];

  quarter_fold #(.ADDR_W(ADDR_W)) u_fold (
    .q   (cur_q),
    .idx (phase_q[PHASE_W-3 -: ADDR_W]),
    .addr(fold_addr),
    .sign(fold_sign)
  );

  always_comb begin
    tune_d       = tune_q;
    phase_d      = phase_q;
    adv_d        = 1'b0;
    rom_addr_d   = rom_addr_q;
    quad_d       = quad_q;
    sign_d       = sign_q;
    addr_valid_d = adv_q;

    // A tick sampled together with a load still uses the old tune_q.
    if (bus.tune_load) tune_d = bus.tune_word;

    if (bus.phase_clr) begin
      phase_d = '0;
    end else if (bus.en && bus.sample_tick) begin
      phase_d = phase_q + tune_q;
      adv_d   = 1'b1;
    end

    if (adv_q) begin
      quad_d = cur_q;
      if (bus.wave_sel == WAVE_SAW) begin
        rom_addr_d = phase_q[PHASE_W-1 -: ADDR_W];
        sign_d     = 1'b0;
      end else begin
        rom_addr_d = fold_addr;
        sign_d     = fold_sign;
      end
    end

    // Stage 0 takes the address-stage flags; the top stage lines up with ROM data.
    dly_vld_d  = ROM_LAT'({dly_vld_q, addr_valid_q});
    dly_sign_d = ROM_LAT'({dly_sign_q, sign_q});
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tune_q       <= '0;
      phase_q      <= '0;
      adv_q        <= 1'b0;
      rom_addr_q   <= '0;
      quad_q       <= '0;
      sign_q       <= 1'b0;
      addr_valid_q <= 1'b0;
      dly_vld_q    <= '0;
      dly_sign_q   <= '0;
    end else begin
      tune_q       <= tune_d;
      phase_q      <= phase_d;
      adv_q        <= adv_d;
      rom_addr_q   <= rom_addr_d;
      quad_q       <= quad_d;
      sign_q       <= sign_d;
      addr_valid_q <= addr_valid_d;
      dly_vld_q    <= dly_vld_d;
      dly_sign_q   <= dly_sign_d;
    end
  end

  assign bus.rom_addr   = rom_addr_q;
  assign bus.addr_valid = addr_valid_q;
  assign bus.quadrant   = quad_q;
  assign bus.data_valid = dly_vld_q[ROM_LAT-1];
  assign bus.neg        = dly_sign_q[ROM_LAT-1];
endmodule

// File: tb/tb_dds_wave_addr_gen.sv
// Directed table of per-cycle vectors plus a hand-written reset-in-flight sequence.
module tb_dds_wave_addr_gen;
  import synth_pkg::*;

  localparam int PW = 24;
  localparam int AW = 10;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dds_wave_addr_gen_if #(.PHASE_W(PW), .ADDR_W(AW)) bus ();

  dds_wave_addr_gen #(.PHASE_W(PW), .ADDR_W(AW), .ROM_LAT(1)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  typedef struct {
    logic          en, tick, load, clr, ws;
    logic [PW-1:0] word;
    logic          av;
    logic [AW-1:0] addr;
    logic [1:0]    q;
    logic          neg, dv;
  } vec_t;

  vec_t tbl[$];
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic vec_t row(input logic en, tick, load, clr, ws, input logic [PW-1:0] word,
                               input logic av, input int addr, input int q, input logic neg, dv);
    vec_t v;
    v.en = en; v.tick = tick; v.load = load; v.clr = clr; v.ws = ws; v.word = word;
    v.av = av; v.addr = AW'(addr); v.q = 2'(q); v.neg = neg; v.dv = dv;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s (step %0d): got %0d, expected %0d", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic en, tick, load, clr, ws, input logic [PW-1:0] word);
    bus.en = en; bus.sample_tick = tick; bus.tune_load = load;
    bus.phase_clr = clr; bus.wave_sel = ws; bus.tune_word = word;
  endtask

  initial begin
    // Columns: en tick load clr ws word | addr_valid rom_addr quadrant neg data_valid
    // Sine, tune 4096: addresses 1,2,3, then a clear.
    tbl.push_back(row(1,0,1,0,0,24'd4096,     0,   0,0,0,0));
    tbl.push_back(row(1,1,0,0,0,0,            0,   0,0,0,0));
    tbl.push_back(row(1,1,0,0,0,0,            1,   1,0,0,0));
    tbl.push_back(row(1,1,0,0,0,0,            1,   2,0,0,1));
    tbl.push_back(row(1,0,0,0,0,0,            1,   3,0,0,1));
    tbl.push_back(row(1,0,0,1,0,0,            0,   3,0,0,1));
    // Sine, tune 2^22: full cycle with wrap at 2^24.
    tbl.push_back(row(1,0,1,0,0,24'h400000,   0,   3,0,0,0));
    tbl.push_back(row(1,1,0,0,0,0,            0,   3,0,0,0));
    tbl.push_back(row(1,1,0,0,0,0,            1,1023,1,0,0));
    tbl.push_back(row(1,1,0,0,0,0,            1,   0,2,0,1));
    tbl.push_back(row(1,1,0,0,0,0,            1,1023,3,1,1));
    tbl.push_back(row(1,1,0,0,0,0,            1,   0,0,1,1));
    tbl.push_back(row(1,0,0,0,0,0,            1,1023,1,0,1));
    tbl.push_back(row(1,0,0,0,0,0,            0,1023,1,0,1));
    tbl.push_back(row(1,0,0,0,0,0,            0,1023,1,0,0));
    // Reach phase 0x123000, then tick together with clear.
    tbl.push_back(row(1,0,1,1,0,24'h123000,   0,1023,1,0,0));
    tbl.push_back(row(1,1,0,0,0,0,            0,1023,1,0,0));
    tbl.push_back(row(1,0,1,0,0,24'd4096,     1, 291,0,0,0));
    tbl.push_back(row(1,1,0,1,0,0,            0, 291,0,0,1));
    tbl.push_back(row(1,0,0,0,0,0,            0, 291,0,0,0));
    tbl.push_back(row(1,1,0,0,0,0,            0, 291,0,0,0));
    tbl.push_back(row(1,0,0,0,0,0,            1,   1,0,0,0));
    tbl.push_back(row(1,0,0,0,0,0,            0,   1,0,0,1));
    // Load 0x2000 on the same edge as a tick: that tick still adds 4096.
    tbl.push_back(row(1,0,0,1,0,0,            0,   1,0,0,0));
    tbl.push_back(row(1,1,1,0,0,24'h002000,   0,   1,0,0,0));
    tbl.push_back(row(1,1,0,0,0,0,            1,   1,0,0,0));
    tbl.push_back(row(1,0,0,0,0,0,            1,   3,0,0,1));
    tbl.push_back(row(1,0,0,0,0,0,            0,   3,0,0,1));
    // Sawtooth with tune 2^22, including two ignored ticks while en is low.
    tbl.push_back(row(1,0,1,1,1,24'h400000,   0,   3,0,0,0));
    tbl.push_back(row(1,1,0,0,1,0,            0,   3,0,0,0));
    tbl.push_back(row(1,1,0,0,1,0,            1, 256,1,0,0));
    tbl.push_back(row(0,1,0,0,1,0,            1, 512,2,0,1));
    tbl.push_back(row(0,1,0,0,1,0,            0, 512,2,0,1));
    tbl.push_back(row(1,1,0,0,1,0,            0, 512,2,0,0));
    tbl.push_back(row(1,1,0,0,1,0,            1, 768,3,0,0));
    tbl.push_back(row(1,0,0,0,1,0,            1,   0,0,0,1));
    tbl.push_back(row(1,0,0,0,1,0,            0,   0,0,0,1));

    rst = 1'b1;
    drive(0,0,0,0,0,'0);
    #12;
    chk("reset rom_addr",   -1, 32'(bus.rom_addr),   0);
    chk("reset addr_valid", -1, 32'(bus.addr_valid), 0);
    chk("reset quadrant",   -1, 32'(bus.quadrant),   0);
    chk("reset data_valid", -1, 32'(bus.data_valid), 0);
    chk("reset neg",        -1, 32'(bus.neg),        0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      drive(tbl[i].en, tbl[i].tick, tbl[i].load, tbl[i].clr, tbl[i].ws, tbl[i].word);
      @(posedge clk);
      #1;
      chk("addr_valid", i, 32'(bus.addr_valid), 32'(tbl[i].av));
      chk("rom_addr",   i, 32'(bus.rom_addr),   32'(tbl[i].addr));
      chk("quadrant",   i, 32'(bus.quadrant),   32'(tbl[i].q));
      chk("data_valid", i, 32'(bus.data_valid), 32'(tbl[i].dv));
      if (tbl[i].dv) chk("neg", i, 32'(bus.neg), 32'(tbl[i].neg));
    end

    // Reset while addr_valid is high and its data_valid is one edge away.
    @(negedge clk); drive(1,1,0,0,WAVE_SINE,'0);
    @(negedge clk); drive(1,0,0,0,WAVE_SINE,'0);
    @(posedge clk); #1;
    chk("pre-reset addr_valid", 100, 32'(bus.addr_valid), 1);
    chk("pre-reset rom_addr",   100, 32'(bus.rom_addr),   1023);
    #1 rst = 1'b1;
    #1;
    chk("mid-reset addr_valid", 101, 32'(bus.addr_valid), 0);
    chk("mid-reset rom_addr",   101, 32'(bus.rom_addr),   0);
    chk("mid-reset quadrant",   101, 32'(bus.quadrant),   0);
    chk("mid-reset data_valid", 101, 32'(bus.data_valid), 0);
    chk("mid-reset neg",        101, 32'(bus.neg),        0);
    @(posedge clk); #1;
    chk("held-reset data_valid", 102, 32'(bus.data_valid), 0);
    @(negedge clk); rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      chk("post-reset data_valid", 103 + k, 32'(bus.data_valid), 0);
      chk("post-reset addr_valid", 103 + k, 32'(bus.addr_valid), 0);
    end

    // Tune register was cleared: reload, then one tick from phase 0.
    @(negedge clk); drive(1,0,1,0,WAVE_SINE,24'h400000);
    @(negedge clk); drive(1,1,0,0,WAVE_SINE,'0);
    @(negedge clk); drive(1,0,0,0,WAVE_SINE,'0);
    @(posedge clk); #1;
    chk("restart addr_valid", 110, 32'(bus.addr_valid), 1);
    chk("restart rom_addr",   110, 32'(bus.rom_addr),   1023);
    chk("restart quadrant",   110, 32'(bus.quadrant),   1);
    @(posedge clk); #1;
    chk("restart data_valid", 111, 32'(bus.data_valid), 1);
    chk("restart neg",        111, 32'(bus.neg),        0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
